rpmp_evt_fifo: RTL and testbench

MSX bus-event capture queue for the RPMP cartridge. Samples MSX slot and I/O cycles on the cartridge edge connector, packs each into a 26-bit event, and buffers the events in a FIFO. The Raspberry Pi drains the FIFO over the 16-bit `r` port using the `ratn`/`cmd`/`ack` handshake. It sits directly downstream of the bus-sampling front end and feeds the Pi-side software.

---
 rtl/rpmp_evt_pkg.sv | 58 +++++
 rtl/rpmp_evt_fifo_if.sv | 26 ++
 rtl/rpmp_evt_sync_fifo.sv | 72 +++++++
 rtl/rpmp_evt_fifo.sv | 158 +++++++++++++++
 tb/tb_rpmp_evt_fifo.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rpmp_evt_pkg.sv
// Shared types for the RPMP MSX bus-event capture queue: event layout,
// type and command codes, handshake states and status-word packing.
package rpmp_evt_pkg;

    localparam int EVT_W = 26;

    typedef enum logic [1:0] {
        EVT_MEM_WR = 2'b00,
        EVT_IO_WR  = 2'b01,
        EVT_MEM_RD = 2'b10,
        EVT_IO_RD  = 2'b11
    } evt_type_e;

    typedef enum logic [1:0] {
        CMD_STATUS = 2'b00,
        CMD_PEEK   = 2'b01,
        CMD_POP    = 2'b10,
        CMD_FLUSH  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ACK  = 2'b10
    } hs_state_e;

    typedef struct packed {
        evt_type_e   typ;
        logic [15:0] addr;
        logic [7:0]  data;
    } evt_t;

    localparam int ST_EMPTY_BIT = 15;
    localparam int ST_FULL_BIT  = 14;
    localparam int ST_OVF_BIT   = 13;

    function automatic evt_type_e evt_type(input logic is_rd, input logic is_io);
        evt_type_e t;
        case ({is_rd, is_io})
            2'b00:   t = EVT_MEM_WR;
            2'b01:   t = EVT_IO_WR;
            2'b10:   t = EVT_MEM_RD;
            default: t = EVT_IO_RD;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] status_word(input logic empty, input logic full,
                                                input logic ovf, input logic [7:0] lvl);
        logic [15:0] w;
        w = {8'h00, lvl};
        w[ST_EMPTY_BIT] = empty;
        w[ST_FULL_BIT]  = full;
        w[ST_OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/rpmp_evt_fifo_if.sv
// MSX edge-connector signals plus the Pi-side ratn/cmd/r/ack handshake.
// The master side is the bus/Pi environment; the slave side is the capture queue.
interface rpmp_evt_fifo_if;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd;
    logic        wr;
    logic        mreq;
    logic        iorq;
    logic        sltsl;
    logic        nwait;
    logic        ratn;
    logic [1:0]  cmd;
    logic [15:0] r;
    logic        ack;

    modport master (
        output a, d, rd, wr, mreq, iorq, sltsl, ratn, cmd,
        input  nwait, r, ack
    );

    modport slave (
        input  a, d, rd, wr, mreq, iorq, sltsl, ratn, cmd,
        output nwait, r, ack
    );
endinterface

// File: rtl/rpmp_evt_sync_fifo.sv
// Single-clock FIFO with show-ahead head, push/pop/flush and an occupancy count.
// Flush overrides everything; a push into a full FIFO is accepted only alongside a pop.
module rpmp_evt_sync_fifo #(
    parameter int WIDTH      = 26,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   level_reg, level_next;
    logic                  push_ok, pop_ok;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LVL_FULL);
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_next = level_reg + (DEPTH_LOG2+1)'(1);
                2'b01:   level_next = level_reg - (DEPTH_LOG2+1)'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/rpmp_evt_fifo.sv
// MSX bus-event capture queue: samples slot/I-O strobes, queues 26-bit events and
// serves them to the Pi over ratn/cmd/r/ack. Optional: RPMP_EVT_WAIT_ON_FULL_EN stalls the MSX near full.
module rpmp_evt_fifo
    import rpmp_evt_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    rpmp_evt_fifo_if.slave      bus,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow
);

    logic        rd_q, wr_q;
    logic        wr_fall, rd_fall, is_mem, is_io;
    logic        cap_valid, cap_read;
    evt_t        cap_evt, head_evt;
    logic [EVT_W-1:0] head_raw;

    logic        fifo_full, fifo_empty, fifo_pop, fifo_flush;
    logic [DEPTH_LOG2:0] level_w;

    logic        ratn_s1_reg, ratn_s_reg, ratn_prev_reg;
    cmd_e        cmd_s1_reg, cmd_s_reg;
    hs_state_e   state_reg, state_next;
    logic        do_action;
    logic [15:0] r_reg, r_next;
    logic        overflow_reg;
    logic        unused_mreq;

    assign unused_mreq = bus.mreq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= 1'b1;
            wr_q <= 1'b1;
        end else begin
            rd_q <= bus.rd;
            wr_q <= bus.wr;
        end
    end

    assign wr_fall   = wr_q & ~bus.wr;
    assign rd_fall   = rd_q & ~bus.rd;
    assign is_mem    = ~bus.sltsl;
    assign is_io     = ~bus.iorq;
    assign cap_valid = (wr_fall | rd_fall) & (is_mem | is_io);
    // A write edge wins over a read edge; a slot select wins over iorq.
    assign cap_read  = ~wr_fall;

    always_comb begin
        cap_evt      = '0;
        cap_evt.typ  = evt_type(cap_read, ~is_mem);
        cap_evt.addr = bus.a;
        cap_evt.data = cap_read ? 8'hFF : bus.d;
    end

    rpmp_evt_sync_fifo #(
        .WIDTH      (EVT_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_valid),
        .push_data (cap_evt),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_w)
    );

    assign head_evt = evt_t'(head_raw);

    // Synchroniser resets high so a ratn still held across reset is not taken as a new request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ratn_s1_reg   <= 1'b1;
            ratn_s_reg    <= 1'b1;
            ratn_prev_reg <= 1'b1;
            cmd_s1_reg    <= CMD_STATUS;
            cmd_s_reg     <= CMD_STATUS;
        end else begin
            ratn_s1_reg   <= bus.ratn;
            ratn_s_reg    <= ratn_s1_reg;
            ratn_prev_reg <= ratn_s_reg;
            cmd_s1_reg    <= cmd_e'(bus.cmd);
            cmd_s_reg     <= cmd_s1_reg;
        end
    end

    // The command executes on the edge into LOAD, so r is valid throughout LOAD.
    always_comb begin
        state_next = state_reg;
        do_action  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ratn_s_reg && !ratn_prev_reg) begin
                    state_next = ST_LOAD;
                    do_action  = 1'b1;
                end
            end
            ST_LOAD: state_next = ST_ACK;
            ST_ACK:  if (!ratn_s_reg) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        r_next     = r_reg;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        if (do_action) begin
            case (cmd_s_reg)
                CMD_STATUS: r_next = status_word(fifo_empty, fifo_full, overflow_reg, 8'(level_w));
                CMD_PEEK:   r_next = fifo_empty ? 16'hFFFF : head_evt.addr;
                CMD_POP: begin
                    r_next   = fifo_empty ? 16'hFFFF : {head_evt.typ, 6'b0, head_evt.data};
                    fifo_pop = ~fifo_empty;
                end
                default: begin
                    r_next     = 16'h0000;
                    fifo_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            r_reg        <= 16'h0000;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            if (fifo_flush)
                overflow_reg <= 1'b0;
            else if (cap_valid && fifo_full && !fifo_pop)
                overflow_reg <= 1'b1;
        end
    end

`ifdef RPMP_EVT_WAIT_ON_FULL_EN
    localparam logic [DEPTH_LOG2:0] LVL_NEAR_FULL = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);
    assign bus.nwait = ~((level_w >= LVL_NEAR_FULL) & (is_mem | is_io));
`else
    assign bus.nwait = 1'b1;
`endif

    assign bus.r    = r_reg;
    assign bus.ack  = (state_reg == ST_ACK);
    assign level    = level_w;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_rpmp_evt_fifo.sv
// Directed bench for rpmp_evt_fifo: captures, handshakes, overflow, flush collision,
// push-while-full-with-pop and reset during a handshake.
module tb_rpmp_evt_fifo;
    import rpmp_evt_pkg::*;

`ifdef RPMP_EVT_WAIT_ON_FULL_EN
    localparam logic NW_NEAR_FULL = 1'b0;
`else
    localparam logic NW_NEAR_FULL = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] level;
    logic       overflow;
    int         checks = 0;
    int         failures = 0;

    rpmp_evt_fifo_if bus();

    rpmp_evt_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_cycle(input logic is_io, input logic is_rd, input logic [15:0] addr,
                             input logic [7:0] data, output logic nw);
        bus.a = addr;
        bus.d = data;
        if (is_io) bus.iorq = 1'b0;
        else begin bus.sltsl = 1'b0; bus.mreq = 1'b0; end
        if (is_rd) bus.rd = 1'b0;
        else       bus.wr = 1'b0;
        #1 nw = bus.nwait;
        @(negedge clk);
        bus.rd = 1'b1; bus.wr = 1'b1; bus.iorq = 1'b1; bus.sltsl = 1'b1; bus.mreq = 1'b1;
        @(negedge clk);
        $display("bus io=%0b rd=%0b a=%h d=%h level=%0d overflow=%0b", is_io, is_rd, addr, data, level, overflow);
    endtask

    task automatic hs_finish(input int start, output logic [15:0] rv);
        int lat;
        int n;
        logic [15:0] r_prev;
        lat = start;
        r_prev = bus.r;
        while (bus.ack !== 1'b1 && lat < 20) begin
            r_prev = bus.r;
            @(negedge clk);
            lat++;
        end
        rv = bus.r;
        check("ack_rise_lat", lat, 4);
        check("r_before_ack", r_prev, rv);
        bus.ratn = 1'b0;
        n = 0;
        while (bus.ack !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_fall_lat", n, 3);
        $display("hs cmd=%0d r=%h level=%0d overflow=%0b", bus.cmd, rv, level, overflow);
    endtask

    task automatic hs(input logic [1:0] c, output logic [15:0] rv);
        bus.cmd  = c;
        bus.ratn = 1'b1;
        hs_finish(0, rv);
    endtask

    // Raises ratn and lands a memory write edge on the same clock as the command action.
    task automatic hs_collide(input logic [1:0] c, input logic [15:0] addr, input logic [7:0] data,
                              output logic [15:0] rv);
        bus.cmd  = c;
        bus.ratn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.a = addr; bus.d = data; bus.sltsl = 1'b0; bus.mreq = 1'b0; bus.wr = 1'b0;
        @(negedge clk);
        bus.wr = 1'b1; bus.sltsl = 1'b1; bus.mreq = 1'b1;
        hs_finish(3, rv);
    endtask

    initial begin
        logic [15:0] rv;
        logic        nw;
        logic        nw_at [17];
        int          n;
        int          acks;

        reset = 1'b1;
        bus.a = '0; bus.d = '0;
        bus.rd = 1'b1; bus.wr = 1'b1; bus.mreq = 1'b1; bus.iorq = 1'b1; bus.sltsl = 1'b1;
        bus.ratn = 1'b0; bus.cmd = 2'b00;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r", bus.r, 16'h0000);
        check("rst_ack", bus.ack, 1'b0);
        check("rst_nwait", bus.nwait, 1'b1);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single memory write, peek and pop
        bus_cycle(1'b0, 1'b0, 16'h4000, 8'h5A, nw);
        check("wr1_level", level, 1);
        hs(CMD_PEEK, rv);
        check("wr1_peek", rv, 16'h4000);
        check("wr1_level_after_peek", level, 1);
        hs(CMD_POP, rv);
        check("wr1_pop", rv, 16'h005A);
        check("wr1_level_after_pop", level, 0);

        // I/O read
        bus_cycle(1'b1, 1'b1, 16'h0098, 8'h00, nw);
        check("iord_level", level, 1);
        hs(CMD_POP, rv);
        check("iord_pop", rv, 16'hC0FF);

        // Pop and status on empty
        hs(CMD_POP, rv);
        check("empty_pop", rv, 16'hFFFF);
        check("empty_pop_level", level, 0);
        hs(CMD_STATUS, rv);
        check("empty_status", rv, 16'h8000);

        // Fill past capacity
        for (int i = 0; i < 17; i++) begin
            bus_cycle(1'b0, 1'b0, 16'(16'h1000 + i), 8'(8'hA0 + i), nw);
            nw_at[i] = nw;
            if (i == 15) begin
                check("fill16_level", level, 16);
                check("fill16_overflow", overflow, 1'b0);
            end
        end
        check("nwait_at_14", nw_at[14], 1'b1);
        check("nwait_at_15", nw_at[15], NW_NEAR_FULL);
        check("fill17_level", level, 16);
        check("fill17_overflow", overflow, 1'b1);
        hs(CMD_STATUS, rv);
        check("full_status", rv, 16'h6010);
        hs(CMD_PEEK, rv);
        check("full_peek", rv, 16'h1000);
        hs(CMD_POP, rv);
        check("full_pop", rv, 16'h00A0);
        hs(CMD_STATUS, rv);
        check("after_pop_status", rv, 16'h200F);

        // Flush in the same cycle as a capture
        hs_collide(CMD_FLUSH, 16'h5555, 8'h77, rv);
        check("flush_r", rv, 16'h0000);
        check("flush_level", level, 0);
        check("flush_overflow", overflow, 1'b0);
        hs(CMD_POP, rv);
        check("flush_event_absent", rv, 16'hFFFF);

        // I/O write and memory read type codes
        bus_cycle(1'b1, 1'b0, 16'h00A8, 8'h55, nw);
        bus_cycle(1'b0, 1'b1, 16'h8123, 8'h00, nw);
        check("types_level", level, 2);
        hs(CMD_PEEK, rv);
        check("iowr_peek", rv, 16'h00A8);
        hs(CMD_POP, rv);
        check("iowr_pop", rv, 16'h4055);
        hs(CMD_POP, rv);
        check("memrd_pop", rv, 16'h80FF);

        // Push while full coinciding with a pop
        for (int i = 0; i < 16; i++)
            bus_cycle(1'b0, 1'b0, 16'(16'h2000 + i), 8'(8'hB0 + i), nw);
        check("refill_level", level, 16);
        hs_collide(CMD_POP, 16'h3333, 8'h99, rv);
        check("pushpop_r", rv, 16'h00B0);
        check("pushpop_level", level, 16);
        check("pushpop_overflow", overflow, 1'b0);

        // Reset while ack is high
        bus.cmd  = CMD_STATUS;
        bus.ratn = 1'b1;
        n = 0;
        while (bus.ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_pre_ack", bus.ack, 1'b1);
        check("rst_mid_pre_r", bus.r, 16'h4010);
        reset = 1'b0;
        #1;
        check("rst_mid_ack", bus.ack, 1'b0);
        check("rst_mid_r", bus.r, 16'h0000);
        check("rst_mid_level", level, 0);
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ack === 1'b1) acks++;
        end
        check("rst_mid_no_ack", acks, 0);
        bus.ratn = 1'b0;
        repeat (4) @(negedge clk);
        hs(CMD_STATUS, rv);
        check("rst_mid_status", rv, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
